// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_evt_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

  localparam logic POL_P = 1'b1;
  localparam logic POL_N = 1'b0;

  localparam int TS_W = 16;

endpackage

// File: rtl/edge_chan.sv
// One monitored channel: edge detection plus one-deep P/N pending slots.
// With EDGE_EVT_TIMESTAMP_EN each slot also keeps the time it was armed.
module edge_chan
  import edge_evt_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cin,
  input  logic            pos_en,
  input  logic            neg_en,
  input  logic            clr_p,
  input  logic            clr_n,
`ifdef EDGE_EVT_TIMESTAMP_EN
  input  logic [TS_W-1:0] tcnt,
  output logic [TS_W-1:0] ts_p,
  output logic [TS_W-1:0] ts_n,
`endif
  output logic            pend_p,
  output logic            pend_n,
  output logic            lost
);

  logic prev;
  logic primed;
  logic set_p;
  logic set_n;

  always_ff @(posedge clk) begin
    prev <= cin;
  end

  // No detection until prev holds a real sample taken after reset.
  assign set_p = primed & pos_en & cin & ~prev;
  assign set_n = primed & neg_en & ~cin & prev;

  // An edge landing on a slot that is being cleared re-arms it without loss.
  assign lost = (set_p & pend_p & ~clr_p) | (set_n & pend_n & ~clr_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed <= 1'b0;
      pend_p <= 1'b0;
      pend_n <= 1'b0;
    end else begin
      primed <= 1'b1;
      pend_p <= set_p | (pend_p & ~clr_p);
      pend_n <= set_n | (pend_n & ~clr_n);
    end
  end

`ifdef EDGE_EVT_TIMESTAMP_EN
  // Overflowing edges keep the original arming time.
  always_ff @(posedge clk) begin
    if (set_p && (!pend_p || clr_p)) ts_p <= tcnt;
    if (set_n && (!pend_n || clr_n)) ts_n <= tcnt;
  end
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter presenting captured edge events over a valid/ready port.
// Define EDGE_EVT_TIMESTAMP_EN to add a free-running counter and evt_time.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          cin,
  input  logic [NCH-1:0]          pos_en,
  input  logic [NCH-1:0]          neg_en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(NCH)-1:0]  evt_chan,
  output logic                    evt_pol,
`ifdef EDGE_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]         evt_time,
`endif
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int CW = $clog2(NCH);

  logic [NCH-1:0] pend_p;
  logic [NCH-1:0] pend_n;
  logic [NCH-1:0] lost;
  logic [NCH-1:0] clr_p;
  logic [NCH-1:0] clr_n;

  arb_state_t     state;
  arb_state_t     state_d;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  cidx;
  logic [CW-1:0]  win_chan;
  logic           win_pol;
  logic           win_found;
  logic           win_hold;
  logic           load;
  logic           accept;

`ifdef EDGE_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] tcnt;
  logic [TS_W-1:0] ts_p [NCH];
  logic [TS_W-1:0] ts_n [NCH];
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    edge_chan u_chan (
      .clk    (clk),
      .rst    (rst),
      .cin    (cin[g]),
      .pos_en (pos_en[g]),
      .neg_en (neg_en[g]),
      .clr_p  (clr_p[g]),
      .clr_n  (clr_n[g]),
`ifdef EDGE_EVT_TIMESTAMP_EN
      .tcnt   (tcnt),
      .ts_p   (ts_p[g]),
      .ts_n   (ts_n[g]),
`endif
      .pend_p (pend_p[g]),
      .pend_n (pend_n[g]),
      .lost   (lost[g])
    );
  end

  // Search starts one past the last granted channel; P wins over N on a channel.
  always_comb begin
    win_found = 1'b0;
    win_chan  = '0;
    win_pol   = POL_P;
    win_hold  = 1'b0;
    cidx      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cidx = CW'((int'(rr_ptr) + i) % NCH);
      if (!win_found && (pend_p[cidx] || pend_n[cidx])) begin
        win_found = 1'b1;
        win_chan  = cidx;
        win_pol   = pend_p[cidx] ? POL_P : POL_N;
        win_hold  = pend_p[cidx] & pend_n[cidx];
      end
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_PRESENT;
          load    = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (evt_ready) begin
          state_d = ST_IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign evt_valid = (state == ST_PRESENT);

  always_comb begin
    clr_p = '0;
    clr_n = '0;
    if (accept) begin
      if (evt_pol == POL_P) clr_p[evt_chan] = 1'b1;
      else                  clr_n[evt_chan] = 1'b1;
    end
  end

  // Pointer stays put while a channel still owes its N event after P.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= CW'(NCH - 1);
      evt_chan <= '0;
      evt_pol  <= POL_N;
      ovf      <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        evt_chan <= win_chan;
        evt_pol  <= win_pol;
        if (!win_hold) rr_ptr <= win_chan;
      end
      if (ovf_clr)    ovf <= 1'b0;
      else if (|lost) ovf <= 1'b1;
    end
  end

`ifdef EDGE_EVT_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) evt_time <= (win_pol == POL_P) ? ts_p[win_chan] : ts_n[win_chan];
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with an expected-event scoreboard.
`timescale 1ns/1ps
module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int NCH = 4;

  typedef struct packed {
    logic [1:0] chan;
    logic       pol;
  } evt_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] cin;
  logic [NCH-1:0] pos_en;
  logic [NCH-1:0] neg_en;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_chan;
  logic           evt_pol;
  logic           ovf;
  logic           ovf_clr;
`ifdef EDGE_EVT_TIMESTAMP_EN
  logic [15:0]    evt_time;
`endif

  evt_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cin       (cin),
    .pos_en    (pos_en),
    .neg_en    (neg_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_pol   (evt_pol),
`ifdef EDGE_EVT_TIMESTAMP_EN
    .evt_time  (evt_time),
`endif
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic evt_t mk(input int c, input logic p);
    evt_t e;
    e.chan = 2'(c);
    e.pol  = p;
    return e;
  endfunction

  // Every accepted handshake must match the head of the expected queue.
  always @(negedge clk) begin : mon
    evt_t e;
    if (!rst && evt_valid && evt_ready) begin
      check("evt_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("evt_chan", 32'(evt_chan), 32'(e.chan));
        check("evt_pol", 32'(evt_pol), 32'(e.pol));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nx(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      nx();
      k++;
    end
    check(tag, 32'(exp_q.size()), 0);
    nx(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cin       = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    nx(2);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_chan", 32'(evt_chan), 0);
    check("rst_pol", 32'(evt_pol), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_ptr", 32'(dut.rr_ptr), NCH - 1);
    @(posedge clk);
    #1 rst = 1'b0;
    nx(2);
  endtask

  initial begin
    int seen;
    rst = 1'b1; cin = '0; pos_en = '1; neg_en = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    do_reset();

    // Single rising edge on channel 2
    evt_ready = 1'b1;
    cin = 4'b0100;
    exp_q.push_back(mk(2, POL_P));
    @(negedge clk); check("single_lat0", 32'(evt_valid), 0);
    nx(); @(negedge clk); check("single_lat1", 32'(evt_valid), 0);
    nx(); @(negedge clk);
    check("single_valid", 32'(evt_valid), 1);
    check("single_chan", 32'(evt_chan), 2);
    check("single_pol", 32'(evt_pol), 1);
    nx(); @(negedge clk); check("single_once", 32'(evt_valid), 0);
    nx(); cin = '0; nx(3);

    // Round-robin order
    do_reset();
    evt_ready = 1'b1;
    cin = 4'b1011;
    exp_q.push_back(mk(0, POL_P));
    exp_q.push_back(mk(1, POL_P));
    exp_q.push_back(mk(3, POL_P));
    drain("rr_drain_a", 40);
    check("rr_ptr_a", 32'(dut.rr_ptr), 3);
    cin = '0; nx(3);
    cin = 4'b1001;
    exp_q.push_back(mk(0, POL_P));
    exp_q.push_back(mk(3, POL_P));
    drain("rr_drain_b", 40);
    check("rr_ptr_b", 32'(dut.rr_ptr), 3);
    cin = '0; nx(3);
    cin = 4'b0010;
    exp_q.push_back(mk(1, POL_P));
    drain("rr_drain_c", 40);
    check("rr_ptr_c", 32'(dut.rr_ptr), 1);
    cin = '0; nx(3);
    cin = 4'b1001;
    exp_q.push_back(mk(3, POL_P));
    exp_q.push_back(mk(0, POL_P));
    drain("rr_drain_d", 40);
    check("rr_ptr_d", 32'(dut.rr_ptr), 0);
    cin = '0; nx(3);

    // Backpressure and overflow on channel 1
    evt_ready = 1'b0;
    cin = 4'b0010; nx(3);
    @(negedge clk);
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_chan", 32'(evt_chan), 1);
    check("bp_ovf0", 32'(ovf), 0);
    nx(); cin = '0; nx(); cin = 4'b0010; nx(2);
    @(negedge clk);
    check("bp_ovf1", 32'(ovf), 1);
    check("bp_hold_valid", 32'(evt_valid), 1);
    check("bp_hold_chan", 32'(evt_chan), 1);
    check("bp_hold_pol", 32'(evt_pol), 1);
    exp_q.push_back(mk(1, POL_P));
    nx(); evt_ready = 1'b1;
    drain("bp_drain", 20);
    nx(4);
    @(negedge clk);
    check("bp_single", 32'(evt_valid), 0);
    check("bp_ovf_sticky", 32'(ovf), 1);
    nx(); ovf_clr = 1'b1; nx(); ovf_clr = 1'b0;
    @(negedge clk); check("ovf_clr", 32'(ovf), 0);

    // Clear wins over a simultaneous overflow on channel 2
    nx(); evt_ready = 1'b0; cin = '0; nx(2);
    cin = 4'b0100; nx(3);
    cin = '0; nx();
    cin = 4'b0100; ovf_clr = 1'b1; nx();
    ovf_clr = 1'b0;
    @(negedge clk); check("ovf_clr_prio", 32'(ovf), 0);
    exp_q.push_back(mk(2, POL_P));
    nx(); evt_ready = 1'b1;
    drain("prio_drain", 20);
    cin = '0; nx(2);

    // Same-channel P then N
    neg_en = 4'hF; nx(2);
    cin = 4'b0001;
    exp_q.push_back(mk(0, POL_P));
    exp_q.push_back(mk(0, POL_N));
    nx(); cin = '0;
    drain("pn_drain", 30);
    neg_en = 4'hE; nx(2);
    cin = 4'b0001;
    exp_q.push_back(mk(0, POL_P));
    nx(); cin = '0;
    drain("p_only_drain", 30);
    nx(4);
    @(negedge clk); check("p_only_idle", 32'(evt_valid), 0);

    // Reset mid-handshake, levels held high through release
    evt_ready = 1'b0; neg_en = '0;
    cin = 4'b1100; nx(3);
    @(negedge clk); check("mid_valid", 32'(evt_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(evt_valid), 0);
    check("rst_async_chan", 32'(evt_chan), 0);
    @(posedge clk); #1 rst = 1'b0;
    evt_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check("rst_no_event", 32'(seen), 0);
    check("rst_ovf_clear", 32'(ovf), 0);

`ifdef EDGE_EVT_TIMESTAMP_EN
    // Timestamp captured just before counter wrap
    evt_ready = 1'b0; cin = '0; pos_en = '1;
    @(negedge clk); rst = 1'b1;
    nx(2);
    rst = 1'b0;
    nx(65534);
    cin = 4'b0001;
    nx(5);
    @(negedge clk);
    check("ts_valid", 32'(evt_valid), 1);
    check("ts_value", 32'(evt_time), 32'h0000FFFE);
    exp_q.push_back(mk(0, POL_P));
    nx(); evt_ready = 1'b1;
    drain("ts_drain", 20);
`endif

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NCH, default 4, sets the number of monitored input channels (2..16).
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-high.
REQ-004 Cin  input  NCH  monitored levels, already synchronous to Clk; bit i is channel i.
REQ-005 Pos_En  input  NCH  per-channel enable for rising-edge capture.
REQ-006 Neg_En  input  NCH  per-channel enable for falling-edge capture.
REQ-007 Evt_Valid  output  1  an event is presented.
REQ-008 Evt_Ready  input  1  the consumer accepts the event.
REQ-009 Evt_Chan  output  clog2(NCH)  channel index of the presented event.
REQ-010 Evt_Pol  output  1  polarity of the presented event: 1 = rising (P), 0 = falling (N).
REQ-011 Ovf  output  1  sticky flag: an edge was lost.
REQ-012 Ovf_Clr  input  1  clears Ovf.

Function
REQ-013 Detection: per channel, register the previous Cin sample; rising edge = Cin & ~prev; falling edge = ~Cin & prev.
REQ-014 A detected edge sets its pending bit (2*NCH bits: one P and one N per channel) only when the matching enable is 1 in that cycle.
REQ-015 Latency: an edge sampled at Clk edge k sets pending at k; with the arbiter idle, Evt_Valid is 1 after edge k+1.
REQ-016 FSM states: IDLE and PRESENT.
- IDLE -> PRESENT when any pending bit is set; the winner is latched into Evt_Chan and Evt_Pol.
- PRESENT -> IDLE when Evt_Valid & Evt_Ready; the winner's pending bit clears in that same cycle.
REQ-017 Evt_Valid equals (state == PRESENT); Evt_Chan and Evt_Pol hold stable while Evt_Valid=1 and Evt_Ready=0.
REQ-018 Arbitration is round-robin over channels, starting at the channel after the last granted channel; the search wraps from NCH-1 to 0.
REQ-019 When P and N are both pending on the same channel, P is granted first and the channel pointer does not advance until N is also served or is not pending.
REQ-020 If an edge arrives while its pending bit is already set, Ovf is set and the pending bit stays set; events never queue deeper than one per slot.
REQ-021 If an edge arrives in the same cycle its pending bit is cleared by acceptance, the pending bit stays set and Ovf is unchanged.
REQ-022 Ovf_Clr has priority over setting Ovf in the same cycle.
REQ-023 Deasserting an enable does not clear an already-pending bit.
REQ-024 Max throughput is one event per 2 cycles, because of the IDLE return.

Reset
REQ-025 While Rst=1: state=IDLE, all pending bits=0, Evt_Valid=0, Evt_Chan=0, Evt_Pol=0, Ovf=0, round-robin pointer=NCH-1 (channel 0 has first priority).
REQ-026 The first cycle after Rst falls loads prev from Cin with no detection, so a high level at reset release produces no spurious rising edge.
REQ-027 Rst asserted mid-handshake drops Evt_Valid immediately and discards all pending events.

Configuration
REQ-028 Macro EDGE_EVT_TIMESTAMP_EN.
- Defined: add a 16-bit free-running counter (reset 0, wraps 0xFFFF->0) and output Evt_Time[15:0], carrying the counter value captured when the presented event's pending bit was set.
- Undefined: no counter, no Evt_Time port; all other behaviour is identical.

Structure
REQ-029 Package edge_evt_pkg holds:
- the FSM state typedef;
- polarity constants POL_P=1 and POL_N=0;
- the timestamp width constant, 16.
REQ-030 Sub-module edge_chan covers one channel: prev register, prime flag, and P/N pending bits with set/clear/overflow logic. It is instantiated NCH times; arbitration and the FSM stay at top level.

Verification
REQ-031 Single edge: NCH=4, Pos_En=4'hF, Cin[2] 0->1, Evt_Ready=1 -> Evt_Valid=1 two cycles later with Evt_Chan=2 and Evt_Pol=1, for exactly one cycle.
REQ-032 Round-robin: rising edges on channels 0, 1 and 3 in the same cycle, Evt_Ready=1 -> grants in order 0, 1, 3; then a new edge on 0 and 3 -> grant 3 before 0 only if the pointer is at 1, otherwise follow the pointer (check the pointer explicitly).
REQ-033 Backpressure/overflow: Evt_Ready=0, two rising edges on channel 1 -> payload stable, Ovf=1, exactly one event delivered once Evt_Ready=1; Ovf_Clr pulse -> Ovf=0.
REQ-034 Same-channel P/N: Cin[0] pulses high for 1 cycle with both enables set -> events (0,P) then (0,N); with Neg_En[0]=0 -> only (0,P).
REQ-035 Reset: Rst pulse while Evt_Valid=1 -> Evt_Valid=0 asynchronously, nothing pending after; Cin held high through reset release -> no event.
REQ-036 With EDGE_EVT_TIMESTAMP_EN: edge detected at counter value 0xFFFE, accepted after wrap -> Evt_Time=0xFFFE.
